// File: rtl/sig_replay.sv
// sig_replay: record-then-replay engine.
// Captures rec_len mic samples into an internal RAM, then streams them back in
// write order over a valid/ready interface, optionally looping until stopped.
module sig_replay #(
   parameter int A_WIDTH = 9,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               loop,
   input  logic [A_WIDTH:0]   rec_len,
   input  logic               sample_en,
   input  logic [D_WIDTH-1:0] mic_signal,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [D_WIDTH-1:0] out_data,
   output logic               busy,
   output logic [1:0]         state,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      PLAY   = 2'd2
   } state_t;

   localparam logic [A_WIDTH:0] FULL_LEN = {1'b1, {A_WIDTH{1'b0}}};
   localparam logic [A_WIDTH:0] ONE_L    = {{A_WIDTH{1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic [A_WIDTH:0]   wr_cnt_q, wr_cnt_d;
   logic [A_WIDTH:0]   len_q, len_d;
   logic [A_WIDTH:0]   rd_idx_q, rd_idx_d;
   logic               fetch_on_q, fetch_on_d;
   logic               pend_q, pend_d;
   logic               pend_last_q, pend_last_d;
   logic               out_valid_q, out_valid_d;
   logic [D_WIDTH-1:0] out_data_q, out_data_d;
   logic               out_last_q, out_last_d;
   logic               skid_valid_q, skid_valid_d;
   logic [D_WIDTH-1:0] skid_data_q, skid_data_d;
   logic               skid_last_q, skid_last_d;
   logic               done_q, done_d;

   logic [D_WIDTH-1:0] mem [2**A_WIDTH];
   logic [D_WIDTH-1:0] ram_rdata;
   logic               wr_en;
   logic [A_WIDTH:0]   len_req;
   logic [A_WIDTH:0]   len_m1;
   logic [1:0]         occ;
   logic               xfer;
   logic               out_free;
   logic               issue;

   // Sample RAM: one write port used while recording, registered read used while playing
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_cnt_q[A_WIDTH-1:0]] <= mic_signal;
      end
      ram_rdata <= mem[rd_idx_q[A_WIDTH-1:0]];
   end

   // Handshake bookkeeping: samples held in out/skid plus the read in flight never exceed two
   always_comb begin
      len_req  = (rec_len > FULL_LEN) ? FULL_LEN : rec_len;
      len_m1   = len_q - ONE_L;
      xfer     = out_valid_q && out_ready;
      out_free = !out_valid_q || xfer;
      occ      = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q};
      issue    = (state_q == PLAY) && fetch_on_q && ((occ - {1'b0, xfer}) <= 2'd1);
   end

   // Next-state, record addressing, prefetch and output staging
   always_comb begin
      state_d      = state_q;
      wr_cnt_d     = wr_cnt_q;
      len_d        = len_q;
      rd_idx_d     = rd_idx_q;
      fetch_on_d   = fetch_on_q;
      pend_d       = 1'b0;
      pend_last_d  = 1'b0;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_last_d  = skid_last_q;
      done_d       = 1'b0;
      wr_en        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && (rec_len != '0)) begin
               state_d  = RECORD;
               wr_cnt_d = '0;
               len_d    = len_req;
            end
         end
         RECORD: begin
            if (stop) begin
               state_d = IDLE;
            end else if (sample_en) begin
               wr_en    = 1'b1;
               wr_cnt_d = wr_cnt_q + ONE_L;
               if (wr_cnt_q == len_m1) begin
                  state_d    = PLAY;
                  rd_idx_d   = '0;
                  fetch_on_d = 1'b1;
               end
            end
         end
         PLAY: begin
            if (stop) begin
               state_d      = IDLE;
               out_valid_d  = 1'b0;
               skid_valid_d = 1'b0;
               fetch_on_d   = 1'b0;
            end else begin
               if (issue) begin
                  pend_d = 1'b1;
                  if (rd_idx_q == len_m1) begin
                     pend_last_d = !loop;
                     rd_idx_d    = '0;
                     fetch_on_d  = loop;
                  end else begin
                     rd_idx_d = rd_idx_q + ONE_L;
                  end
               end
               if (out_free) begin
                  if (skid_valid_q) begin
                     out_valid_d  = 1'b1;
                     out_data_d   = skid_data_q;
                     out_last_d   = skid_last_q;
                     skid_valid_d = pend_q;
                     skid_data_d  = ram_rdata;
                     skid_last_d  = pend_last_q;
                  end else if (pend_q) begin
                     out_valid_d = 1'b1;
                     out_data_d  = ram_rdata;
                     out_last_d  = pend_last_q;
                  end else begin
                     out_valid_d = 1'b0;
                  end
               end else if (pend_q) begin
                  skid_valid_d = 1'b1;
                  skid_data_d  = ram_rdata;
                  skid_last_d  = pend_last_q;
               end
               if (xfer && out_last_q) begin
                  done_d       = 1'b1;
                  state_d      = IDLE;
                  out_valid_d  = 1'b0;
                  skid_valid_d = 1'b0;
                  pend_d       = 1'b0;
                  fetch_on_d   = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; RAM contents are left untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wr_cnt_q     <= '0;
         len_q        <= '0;
         rd_idx_q     <= '0;
         fetch_on_q   <= 1'b0;
         pend_q       <= 1'b0;
         pend_last_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_last_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_cnt_q     <= wr_cnt_d;
         len_q        <= len_d;
         rd_idx_q     <= rd_idx_d;
         fetch_on_q   <= fetch_on_d;
         pend_q       <= pend_d;
         pend_last_q  <= pend_last_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_last_q  <= skid_last_d;
         done_q       <= done_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != IDLE);
   assign state     = state_q;
   assign done      = done_q;

endmodule

// File: tb/tb_sig_replay.sv
// Self-checking bench for sig_replay: records random or patterned samples,
// replays them under several out_ready patterns and compares against a queue model.
module tb_sig_replay;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       loop;
   logic [9:0] rec_len;
   logic       sample_en;
   logic [7:0] mic_signal;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       busy;
   logic [1:0] state;
   logic       done;

   int checks = 0;
   int errors = 0;

   logic [7:0] rec_data[$];
   logic [7:0] got_q[$];
   int         col_first_lat;
   int         col_bubbles;
   int         col_stalls_bad;
   int         col_early_done;
   bit         col_timeout;
   logic       post_done;
   logic [1:0] post_state;
   logic       post_valid;

   sig_replay #(.A_WIDTH(9), .D_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
      .rec_len(rec_len), .sample_en(sample_en), .mic_signal(mic_signal),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .busy(busy), .state(state), .done(done)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulses start and feeds nwrites samples from rec_data; optionally pokes start mid-record
   task automatic record(input int len_req, input int nwrites, input int en_mode, input bit poke);
      int writes;
      int cyc;
      logic en;
      rec_len = len_req[9:0];
      start   = 1'b1;
      step();
      start  = 1'b0;
      writes = 0;
      cyc    = 0;
      while (writes < nwrites && cyc < 100000) begin
         if (en_mode == 0) en = 1'b1;
         else if (en_mode == 1) en = (cyc % 3 == 2);
         else en = ($urandom_range(0, 1) == 1) || (cyc % 4 == 3);
         if (poke && cyc == 1) begin
            start   = 1'b1;
            rec_len = 10'd2;
         end else begin
            start = 1'b0;
         end
         sample_en  = en;
         mic_signal = rec_data[writes];
         if (en) writes++;
         cyc++;
         step();
      end
      start     = 1'b0;
      sample_en = 1'b0;
   endtask

   // Drives out_ready per mode and gathers n transferred samples plus handshake statistics
   task automatic collect(input int n, input int mode);
      bit         prev_hold;
      logic [7:0] prev_data;
      logic       rdy;
      int         budget;
      got_q.delete();
      col_first_lat  = -1;
      col_bubbles    = 0;
      col_stalls_bad = 0;
      col_early_done = 0;
      col_timeout    = 1'b0;
      prev_hold      = 1'b0;
      prev_data      = '0;
      budget         = n * 20 + 50;
      for (int cyc = 0; cyc < budget && got_q.size() < n; cyc++) begin
         if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_data)) col_stalls_bad++;
         if (done === 1'b1) col_early_done++;
         if (out_valid === 1'b1 && col_first_lat < 0) col_first_lat = cyc;
         if (mode == 0) rdy = 1'b1;
         else if (mode == 1) rdy = (cyc % 3 == 0);
         else rdy = ($urandom_range(0, 1) == 1);
         out_ready = rdy;
         if (col_first_lat >= 0 && rdy && out_valid !== 1'b1) col_bubbles++;
         if (out_valid === 1'b1 && rdy) got_q.push_back(out_data);
         prev_hold = (out_valid === 1'b1) && !rdy;
         prev_data = out_data;
         step();
      end
      if (got_q.size() < n) col_timeout = 1'b1;
      post_done  = done;
      post_state = state;
      post_valid = out_valid;
      out_ready  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", state); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_data got %0d want 0", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      rec_data = '{8'd10, 8'd20, 8'd30, 8'd40};
      loop = 1'b0;
      record(4, 4, 0, 1'b0);
      checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL basic_play_state got %0d want 2", state); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b want 1", busy); end
      collect(4, 0);
      checks++; if (col_timeout !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout got %0d samples want 4", got_q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (got_q[i] !== rec_data[i]) begin errors++; $display("[TB] FAIL basic_data[%0d] got %0d want %0d", i, got_q[i], rec_data[i]); end
      end
      checks++; if (col_first_lat < 0 || col_first_lat > 2) begin errors++; $display("[TB] FAIL basic_latency got %0d want <=2", col_first_lat); end
      checks++; if (col_bubbles !== 0) begin errors++; $display("[TB] FAIL basic_bubbles got %0d want 0", col_bubbles); end
      checks++; if (post_done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done got %b want 1", post_done); end
      checks++; if (post_state !== 2'd0) begin errors++; $display("[TB] FAIL basic_end_state got %0d want 0", post_state); end
      checks++; if (post_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_end_valid got %b want 0", post_valid); end
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %b want 0", done); end
   endtask

   task automatic test_backpressure();
      rec_data = '{8'd10, 8'd20, 8'd30, 8'd40};
      loop = 1'b0;
      record(4, 4, 0, 1'b0);
      collect(4, 1);
      checks++; if (col_timeout !== 1'b0) begin errors++; $display("[TB] FAIL bp_timeout got %0d samples want 4", got_q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (got_q[i] !== rec_data[i]) begin errors++; $display("[TB] FAIL bp_data[%0d] got %0d want %0d", i, got_q[i], rec_data[i]); end
      end
      checks++; if (col_stalls_bad !== 0) begin errors++; $display("[TB] FAIL bp_hold got %0d violations want 0", col_stalls_bad); end
      checks++; if (col_early_done !== 0) begin errors++; $display("[TB] FAIL bp_early_done got %0d want 0", col_early_done); end
      checks++; if (post_done !== 1'b1) begin errors++; $display("[TB] FAIL bp_done got %b want 1", post_done); end
      step();
   endtask

   task automatic test_loop();
      rec_data = '{8'd1, 8'd2, 8'd3};
      loop = 1'b1;
      record(3, 3, 0, 1'b0);
      collect(6, 0);
      checks++; if (col_timeout !== 1'b0) begin errors++; $display("[TB] FAIL loop_timeout got %0d samples want 6", got_q.size()); end
      for (int i = 0; i < 6; i++) begin
         checks++; if (got_q[i] !== rec_data[i % 3]) begin errors++; $display("[TB] FAIL loop_data[%0d] got %0d want %0d", i, got_q[i], rec_data[i % 3]); end
      end
      checks++; if (col_bubbles !== 0) begin errors++; $display("[TB] FAIL loop_bubbles got %0d want 0", col_bubbles); end
      checks++; if (post_done !== 1'b0) begin errors++; $display("[TB] FAIL loop_no_done got %b want 0", post_done); end
      checks++; if (post_state !== 2'd2) begin errors++; $display("[TB] FAIL loop_still_play got %0d want 2", post_state); end
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL loop_stop_state got %0d want 0", state); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL loop_stop_valid got %b want 0", out_valid); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL loop_stop_done got %b want 0", done); end
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL loop_stop_done2 got %b want 0", done); end
      loop = 1'b0;
   endtask

   task automatic test_full_depth();
      rec_data.delete();
      for (int i = 0; i < 512; i++) rec_data.push_back(8'(i));
      loop = 1'b0;
      record(512, 512, 1, 1'b0);
      checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL full_play_state got %0d want 2", state); end
      collect(512, 0);
      checks++; if (col_timeout !== 1'b0) begin errors++; $display("[TB] FAIL full_timeout got %0d samples want 512", got_q.size()); end
      for (int i = 0; i < 512; i++) begin
         checks++; if (got_q[i] !== 8'(i % 256)) begin errors++; $display("[TB] FAIL full_data[%0d] got %0d want %0d", i, got_q[i], i % 256); end
      end
      checks++; if (post_done !== 1'b1) begin errors++; $display("[TB] FAIL full_done got %b want 1", post_done); end
      step();
   endtask

   task automatic test_clamp();
      rec_data.delete();
      for (int i = 0; i < 512; i++) rec_data.push_back(8'($urandom_range(0, 255)));
      loop = 1'b0;
      record(700, 512, 0, 1'b0);
      checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL clamp_play_state got %0d want 2", state); end
      collect(512, 2);
      checks++; if (col_timeout !== 1'b0) begin errors++; $display("[TB] FAIL clamp_timeout got %0d samples want 512", got_q.size()); end
      for (int i = 0; i < 512; i++) begin
         checks++; if (got_q[i] !== rec_data[i]) begin errors++; $display("[TB] FAIL clamp_data[%0d] got %0d want %0d", i, got_q[i], rec_data[i]); end
      end
      checks++; if (col_stalls_bad !== 0) begin errors++; $display("[TB] FAIL clamp_hold got %0d violations want 0", col_stalls_bad); end
      checks++; if (post_done !== 1'b1) begin errors++; $display("[TB] FAIL clamp_done got %b want 1", post_done); end
      step();
   endtask

   task automatic test_start_rules();
      rec_len = 10'd0;
      start   = 1'b1;
      step();
      start = 1'b0;
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL len0_state got %0d want 0", state); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL len0_busy got %b want 0", busy); end
      stop = 1'b1;
      step();
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL idle_stop_state got %0d want 0", state); end
      rec_len = 10'd5;
      start   = 1'b1;
      step();
      start = 1'b0;
      checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL start_stop_state got %0d want 1", state); end
      step();
      stop = 1'b0;
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL record_stop_state got %0d want 0", state); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL record_stop_done got %b want 0", done); end
      rec_data = '{8'd7, 8'd77, 8'd177, 8'd17, 8'd71};
      loop = 1'b0;
      record(5, 5, 0, 1'b1);
      checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL ignore_start_state got %0d want 2", state); end
      collect(5, 0);
      checks++; if (col_timeout !== 1'b0) begin errors++; $display("[TB] FAIL ignore_start_timeout got %0d samples want 5", got_q.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (got_q[i] !== rec_data[i]) begin errors++; $display("[TB] FAIL ignore_start_data[%0d] got %0d want %0d", i, got_q[i], rec_data[i]); end
      end
      checks++; if (post_done !== 1'b1) begin errors++; $display("[TB] FAIL ignore_start_done got %b want 1", post_done); end
      step();
   endtask

   task automatic test_reset_mid_play();
      rec_data = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
      loop = 1'b0;
      record(8, 8, 0, 1'b0);
      collect(3, 0);
      checks++; if (got_q[2] !== 8'd7) begin errors++; $display("[TB] FAIL midplay_data got %0d want 7", got_q[2]); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL midplay_rst_state got %0d want 0", state); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midplay_rst_valid got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midplay_rst_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midplay_rst_done got %b want 0", done); end
      step();
   endtask

   task automatic test_back_to_back();
      int len;
      int n;
      for (int it = 0; it < 8; it++) begin
         len = $urandom_range(1, 24);
         loop = ($urandom_range(0, 1) == 1);
         rec_data.delete();
         for (int i = 0; i < len; i++) rec_data.push_back(8'($urandom_range(0, 255)));
         n = loop ? (2 * len + 1) : len;
         record(len, len, 2, 1'b0);
         collect(n, 2);
         checks++; if (col_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_timeout got %0d samples want %0d", it, got_q.size(), n); end
         for (int i = 0; i < n; i++) begin
            checks++; if (got_q[i] !== rec_data[i % len]) begin errors++; $display("[TB] FAIL rnd%0d_data[%0d] got %0d want %0d", it, i, got_q[i], rec_data[i % len]); end
         end
         checks++; if (col_stalls_bad !== 0) begin errors++; $display("[TB] FAIL rnd%0d_hold got %0d violations want 0", it, col_stalls_bad); end
         checks++; if (post_done !== !loop) begin errors++; $display("[TB] FAIL rnd%0d_done got %b want %b", it, post_done, !loop); end
         if (loop) begin
            stop = 1'b1;
            step();
            stop = 1'b0;
            checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rnd%0d_stop_state got %0d want 0", it, state); end
         end
      end
      loop = 1'b0;
   endtask

   // Test sequence
   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      stop       = 1'b0;
      loop       = 1'b0;
      rec_len    = '0;
      sample_en  = 1'b0;
      mic_signal = '0;
      out_ready  = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_loop();
      test_full_depth();
      test_clamp();
      test_start_rules();
      test_reset_mid_play();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
